// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if -- Wishbone B3 classic bus bundle for the irq_ctrl register file.
//
// Signals (names as seen from the slave):
//   wb_adr_i  [2:0]  word address of the register
//   wb_dat_i  [31:0] write data
//   wb_we_i          write enable
//   wb_cyc_i         bus cycle in progress
//   wb_stb_i         strobe
//   wb_dat_o  [31:0] registered read data
//   wb_ack_o         transfer acknowledge
//   wb_err_o         transfer error (unmapped address)
//
// Modports: master (CPU / bench side), slave (irq_ctrl side).
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- interrupt controller with per-source level/edge detection,
// pending latch, mask and a Wishbone B3 classic register interface.
//
// Parameters:
//   NUM_SRC    number of implemented sources (1..32); higher bits read 0
//   RESET_MASK reset value of the MASK register
//
// Ports:
//   wb_clk_i        clock, all state on its rising edge
//   wb_rst_i        asynchronous active-high reset
//   wb              irq_ctrl_if.slave register bus
//   irq_i   [31:0]  peripheral interrupt sources (asynchronous)
//   irq_o   [31:0]  registered pending & mask vector to the CPU PIC
//
// Register map (word address):
//   0 STATUS  RO   pending & mask
//   1 PENDING R/W1C
//   2 MASK    RW   1 = enabled
//   3 EDGE    RW   1 = rising edge, 0 = level
//   4 RAW     RO   sampled inputs
//   5 SWSET   WO   write 1 sets pending, reads 0
//   6,7       error response, no effect
//
// Build option: define IRQ_CTRL_SYNC_EN to put a two-flop synchronizer in
// front of the detectors (one extra cycle of input latency).
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int unsigned NUM_SRC    = 32,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    irq_ctrl_if.slave   wb,
    input  logic [31:0] irq_i,
    output logic [31:0] irq_o
);

    typedef enum logic [2:0] {
        ADR_STATUS  = 3'd0,
        ADR_PENDING = 3'd1,
        ADR_MASK    = 3'd2,
        ADR_EDGE    = 3'd3,
        ADR_RAW     = 3'd4,
        ADR_SWSET   = 3'd5
    } reg_adr_e;

    // Bits of implemented sources; everything above NUM_SRC is forced to 0.
    localparam logic [31:0] IMPL_MASK = 32'hFFFF_FFFF >> (32 - NUM_SRC);

    logic [31:0] s;          // sampled inputs (RAW)
    logic [31:0] s_d;        // s delayed one cycle, for rising-edge detect
    logic [31:0] pending;
    logic [31:0] mask;
    logic [31:0] edge_mode;
    logic [31:0] irq_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;

    logic        bus_req;
    logic        adr_ok;
    logic        wr_en;
    logic [31:0] w1c;
    logic [31:0] sw_set;
    logic [31:0] set_vec;
    logic [31:0] pending_nxt;
    logic [31:0] rd_data;

    // ---------------------------------------------------------------- sampling
`ifdef IRQ_CTRL_SYNC_EN
    logic [31:0] meta;

    // The metastability flop plus s itself form the two-flop synchronizer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            meta <= '0;
            s    <= '0;
        end else begin
            meta <= irq_i & IMPL_MASK;
            s    <= meta;
        end
    end
`else
    // NOTE: async reset sits in the sensitivity list so flops clear without a clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) s <= '0;
        else          s <= irq_i & IMPL_MASK;
    end
`endif

    // ---------------------------------------------------------------- bus decode
    // A new request is only accepted while no response is showing, which
    // guarantees at least one idle cycle between consecutive ack/err pulses.
    assign bus_req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign adr_ok  = (wb.wb_adr_i <= ADR_SWSET);
    assign wr_en   = bus_req & adr_ok & wb.wb_we_i;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w1c     = '0;
        sw_set  = '0;
        rd_data = '0;

        if (wr_en && wb.wb_adr_i == ADR_PENDING) w1c    = wb.wb_dat_i & IMPL_MASK;
        if (wr_en && wb.wb_adr_i == ADR_SWSET)   sw_set = wb.wb_dat_i & IMPL_MASK;

        // Level sources set while high; edge sources only on 0->1 of s.
        set_vec     = ((s & ~edge_mode) | (s & ~s_d & edge_mode) | sw_set) & IMPL_MASK;
        // Set is applied after clear so a coincident set wins.
        pending_nxt = (pending & ~w1c) | set_vec;

        case (wb.wb_adr_i)
            ADR_STATUS:  rd_data = pending & mask;
            ADR_PENDING: rd_data = pending;
            ADR_MASK:    rd_data = mask;
            ADR_EDGE:    rd_data = edge_mode;
            ADR_RAW:     rd_data = s;
            default:     rd_data = '0;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s_d       <= '0;
            pending   <= '0;
            mask      <= RESET_MASK & IMPL_MASK;
            edge_mode <= '0;
            irq_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            s_d     <= s;
            pending <= pending_nxt;
            // Registered from the current pending, so irq_o trails pending by one cycle.
            irq_q   <= pending & mask;

            if (wr_en && wb.wb_adr_i == ADR_MASK) mask      <= wb.wb_dat_i & IMPL_MASK;
            if (wr_en && wb.wb_adr_i == ADR_EDGE) edge_mode <= wb.wb_dat_i & IMPL_MASK;

            ack_q <= bus_req & adr_ok;
            err_q <= bus_req & ~adr_ok;
            dat_q <= (bus_req && adr_ok && !wb.wb_we_i) ? rd_data : '0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// Two instances share clock and reset: dut0 (NUM_SRC=32, RESET_MASK=0x30) and
// dut1 (NUM_SRC=12, RESET_MASK=0xFFFFF00F). Bus transfers push their expected
// response to a scoreboard queue; it is popped when ack/err appears.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_EDGE    = 3'd3;
    localparam logic [2:0] A_RAW     = 3'd4;
    localparam logic [2:0] A_SWSET   = 3'd5;

    typedef struct {
        string       tag;
        logic [31:0] data;
        bit          err;
        bit          is_rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] irq0, irq1;
    logic [31:0] irq_o0, irq_o1;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    irq_ctrl_if bus0();
    irq_ctrl_if bus1();

    irq_ctrl #(.NUM_SRC(32), .RESET_MASK(32'h0000_0030)) dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus0.slave),
        .irq_i    (irq0),
        .irq_o    (irq_o0)
    );

    irq_ctrl #(.NUM_SRC(12), .RESET_MASK(32'hFFFF_F00F)) dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus1.slave),
        .irq_i    (irq1),
        .irq_o    (irq_o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit sel, input logic [2:0] adr, input logic [31:0] dat,
                             input logic we, input logic active);
        if (!sel) begin
            bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_we_i = we;
            bus0.wb_cyc_i = active; bus0.wb_stb_i = active;
        end else begin
            bus1.wb_adr_i = adr; bus1.wb_dat_i = dat; bus1.wb_we_i = we;
            bus1.wb_cyc_i = active; bus1.wb_stb_i = active;
        end
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? bus1.wb_ack_o : bus0.wb_ack_o;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? bus1.wb_err_o : bus0.wb_err_o;
    endfunction

    function automatic logic [31:0] rd_dat(input bit sel);
        return sel ? bus1.wb_dat_o : bus0.wb_dat_o;
    endfunction

    task automatic bus_xfer(input bit sel, input logic we, input logic [2:0] adr,
                            input logic [31:0] wdat, input logic [31:0] exp_dat,
                            input bit exp_err, input string tag);
        exp_t e;
        bit   seen;
        e.tag = tag; e.data = exp_dat; e.err = exp_err; e.is_rd = !we;
        sb_q.push_back(e);
        drive_req(sel, adr, wdat, we, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (get_ack(sel) || get_err(sel)) seen = 1'b1;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            check({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({e.tag, "_err"}, 32'(get_err(sel)), 32'(e.err));
            check({e.tag, "_ack"}, 32'(get_ack(sel)), 32'(!e.err));
            if (e.is_rd) check(e.tag, rd_dat(sel), e.data);
        end
        drive_req(sel, 3'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check({e.tag, "_idle"}, {30'd0, get_ack(sel), get_err(sel)}, 32'd0);
    endtask

    task automatic wr(input bit sel, input logic [2:0] adr, input logic [31:0] d, input string tag);
        bus_xfer(sel, 1'b1, adr, d, 32'd0, 1'b0, tag);
    endtask

    task automatic rd(input bit sel, input logic [2:0] adr, input logic [31:0] exp_d, input string tag);
        bus_xfer(sel, 1'b0, adr, 32'd0, exp_d, 1'b0, tag);
    endtask

    initial begin
        rst  = 1'b1;
        irq0 = '0;
        irq1 = '0;
        drive_req(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        drive_req(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_irq_o0", irq_o0, 32'd0);
        check("rst_ack0", 32'(bus0.wb_ack_o), 32'd0);
        check("rst_dat0", bus0.wb_dat_o, 32'd0);
        rst = 1'b0;
        tick();
        rd(0, A_MASK,    32'h0000_0030, "rst_mask0");
        rd(0, A_EDGE,    32'h0,         "rst_edge0");
        rd(0, A_PENDING, 32'h0,         "rst_pend0");
        rd(1, A_MASK,    32'h0000_000F, "rst_mask1");

        // ---- level source on bit 2
        wr(0, A_MASK, 32'h4, "lvl_mask");
        irq0[2] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check($sformatf("lvl_lat%0d", k), irq_o0, (k >= LAT) ? 32'h4 : 32'h0);
        end
        wr(0, A_PENDING, 32'h4, "lvl_w1c_hi");
        check("lvl_hold0", irq_o0, 32'h4);
        tick();
        tick();
        check("lvl_hold1", irq_o0, 32'h4);
        irq0[2] = 1'b0;
        repeat (LAT) tick();
        check("lvl_latched", irq_o0, 32'h4);
        wr(0, A_PENDING, 32'h4, "lvl_w1c_lo");
        check("lvl_clr0", irq_o0, 32'h0);
        tick();
        check("lvl_clr1", irq_o0, 32'h0);
        rd(0, A_PENDING, 32'h0, "lvl_pend");

        // ---- edge source on bit 10, one-cycle pulse
        wr(0, A_EDGE, 32'h400, "edg_edge");
        wr(0, A_MASK, 32'h400, "edg_mask");
        irq0[10] = 1'b1;
        tick();
        irq0[10] = 1'b0;
        repeat (LAT + 2) tick();
        check("edg_irq", irq_o0, 32'h400);
        rd(0, A_PENDING, 32'h400, "edg_pend");
        rd(0, A_STATUS,  32'h400, "edg_status");
        check("edg_held", irq_o0, 32'h400);
        wr(0, A_PENDING, 32'h400, "edg_w1c");
        check("edg_clr", irq_o0, 32'h0);

        // ---- rising edge on bit 11 coinciding with its W1C: set wins
        wr(0, A_EDGE, 32'hC00, "sim_edge");
        wr(0, A_MASK, 32'hC00, "sim_mask");
        irq0[11] = 1'b1;
        repeat (LAT - 2) tick();
        wr(0, A_PENDING, 32'h800, "sim_w1c");
        rd(0, A_PENDING, 32'h800, "sim_pend");
        irq0[11] = 1'b0;
        wr(0, A_PENDING, 32'h800, "sim_w1c2");
        rd(0, A_PENDING, 32'h0, "sim_pend_clr");

        // ---- bus errors, SWSET and unmask
        bus_xfer(0, 1'b0, 3'd6, 32'd0, 32'd0, 1'b1, "err_rd6");
        bus_xfer(0, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'd0, 1'b1, "err_wr7");
        rd(0, A_PENDING, 32'h0, "err_nowrite");
        wr(0, A_MASK,  32'h0, "sw_mask0");
        wr(0, A_SWSET, 32'h1, "sw_set");
        rd(0, A_STATUS,  32'h0, "sw_status");
        rd(0, A_PENDING, 32'h1, "sw_pend");
        rd(0, A_SWSET,   32'h0, "sw_rd0");
        check("sw_masked", irq_o0, 32'h0);
        wr(0, A_MASK, 32'h1, "sw_unmask");
        check("sw_irq", irq_o0, 32'h1);
        repeat (3) tick();
        check("sw_persist", irq_o0, 32'h1);
        rd(0, A_EDGE, 32'hC00, "edge_rb");

        // ---- RAW readback
        irq0 = 32'h3;
        repeat (LAT) tick();
        rd(0, A_RAW, 32'h3, "raw");
        irq0 = '0;

        // ---- NUM_SRC = 12 instance
        irq1 = 32'hFFFF_F000;
        repeat (LAT + 1) tick();
        rd(1, A_PENDING, 32'h0, "n12_hi_pend");
        rd(1, A_RAW,     32'h0, "n12_hi_raw");
        irq1 = '0;
        wr(1, A_PENDING, 32'hFFFF_FFFF, "n12_w1c");
        wr(1, A_SWSET,   32'hFFFF_FFFF, "n12_swset");
        wr(1, A_MASK,    32'hFFFF_FFFF, "n12_mask");
        rd(1, A_MASK,    32'h0000_0FFF, "n12_mask_rb");
        rd(1, A_PENDING, 32'h0000_0FFF, "n12_pend");
        rd(1, A_STATUS,  32'h0000_0FFF, "n12_status");
        check("n12_irq", irq_o1, 32'h0000_0FFF);
        wr(1, A_EDGE, 32'hFFFF_FFFF, "n12_edge");
        rd(1, A_EDGE, 32'h0000_0FFF, "n12_edge_rb");

        // ---- reset during a write ack cycle
        drive_req(0, A_MASK, 32'h0000_00FF, 1'b1, 1'b1);
        tick();
        check("rstw_ack_pre", 32'(bus0.wb_ack_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_ack", 32'(bus0.wb_ack_o), 32'd0);
        check("rstw_err", 32'(bus0.wb_err_o), 32'd0);
        check("rstw_dat", bus0.wb_dat_o, 32'd0);
        check("rstw_irq", irq_o0, 32'd0);
        drive_req(0, 3'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstw_noack%0d", k), {30'd0, bus0.wb_ack_o, bus0.wb_err_o}, 32'd0);
        end
        rd(0, A_MASK,    32'h0000_0030, "rstw_mask");
        rd(0, A_PENDING, 32'h0,         "rstw_pend");
        rd(0, A_EDGE,    32'h0,         "rstw_edge");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 32, number of implemented sources (1..32).
REQ-002 SHALL have parameter RESET_MASK, default 32'h0, MASK register reset value.
REQ-003 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 wb_adr_i  in  3  word address of the register.
REQ-006 wb_dat_i  in  32  write data.
REQ-007 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone B3 classic slave controls.
REQ-008 wb_dat_o  out  32  read data.
REQ-009 wb_ack_o  out  1  transfer acknowledge.
REQ-010 wb_err_o  out  1  transfer error.
REQ-011 irq_i  in  32  peripheral interrupt sources, asynchronous to wb_clk_i.
REQ-012 irq_o  out  32  masked interrupt vector to the CPU PIC.

Function
REQ-013 Register map by wb_adr_i: 0 STATUS (RO, pending&mask), 1 PENDING (R/W1C), 2 MASK (RW, 1=enabled), 3 EDGE (RW, 1=rising-edge, 0=level), 4 RAW (RO, sampled inputs), 5 SWSET (WO, write 1 sets pending, reads 0).
REQ-014 Bus cycle: wb_cyc_i&wb_stb_i high with wb_ack_o and wb_err_o low -> exactly one of ack/err high for one cycle on the next edge, then low for at least one cycle.
REQ-015 Addresses 6,7 -> wb_err_o instead of wb_ack_o; writes ignored, wb_dat_o 0.
REQ-016 Read data SHALL be registered and valid in the cycle wb_ack_o is high; wb_dat_o is 0 otherwise.
REQ-017 Writes take effect on the edge that asserts wb_ack_o; writes to RO registers are ignored.
REQ-018 Bits at index >= NUM_SRC SHALL read 0, never set pending, and keep irq_o at 0.
REQ-019 Sampled input s: one register stage of irq_i (see REQ-030 for the sync option); s_d is s delayed one cycle.
REQ-020 Level source: pending bit set on every edge where s is 1.
REQ-021 Edge source: pending bit set on the edge where s=1 and s_d=0; it remains set until cleared.
REQ-022 Pending bit cleared by a PENDING write with 1 in that bit; if a set condition (REQ-020/021 or SWSET) occurs on the same edge, set wins.
REQ-023 A level source still asserted re-sets its pending bit on the edge after a W1C.
REQ-024 SWSET sets pending in either mode; the bit persists until W1C, and in level mode it is not auto-cleared by a low input.
REQ-025 irq_o SHALL be a registered copy of pending&mask, one cycle after pending changes.
REQ-026 Latency without sync: irq_i rising before edge 1 -> s at edge 1, pending at edge 2, irq_o at edge 3.
REQ-027 Changing MASK or EDGE does not alter pending; unmasking an already-pending bit raises irq_o one cycle after the write edge.

Reset
REQ-028 Asynchronous reset (wb_rst_i high): pending=0, EDGE=0, MASK=RESET_MASK, s/s_d/sync flops=0, irq_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-029 Reset mid-transfer SHALL drop ack/err immediately and discard the write; there is no ack after release unless a new strobe is seen.

Configuration
REQ-030 Macro IRQ_CTRL_SYNC_EN defined: two-flop synchronizer before s, adding one cycle (irq_o at edge 4 per REQ-026). Undefined: single sample register, latency per REQ-026.

Verification
REQ-031 Level: irq_i[2]=1, MASK=4, EDGE=0 -> irq_o=32'h4 at edge 3 (4 with sync); W1C PENDING=4 while high -> irq_o remains 4; irq_i[2]=0, then W1C -> irq_o=0.
REQ-032 Edge: EDGE=32'h400, MASK=32'h400, 1-cycle pulse on irq_i[10] -> PENDING reads 32'h400, irq_o[10]=1 held; W1C 32'h400 -> irq_o=0 two cycles later.
REQ-033 Simultaneous: a rising edge on irq_i[11] (edge mode) on the same edge as W1C 32'h800 -> PENDING bit 11 remains 1.
REQ-034 Bus: read adr 6 -> wb_err_o one cycle, wb_ack_o 0; write SWSET=32'h1 with MASK=0 -> STATUS=0, PENDING=1; then write MASK=1 -> irq_o=1.
REQ-035 NUM_SRC=12: write PENDING/SWSET/MASK=32'hFFFFFFFF -> MASK reads 32'hFFF, irq_o[31:12]=0.
REQ-036 Assert wb_rst_i during a write ack cycle -> ack drops asynchronously, the register keeps its reset value, and MASK=RESET_MASK.
